// File: rtl/thermocouple_scanner.sv
// Multi-channel MAX31855-style poller: after a power-up delay it walks the enabled channels
// through a shared SPI master, unpacking each 32-bit reply into per-channel fields.
module thermocouple_scanner #(
    parameter int unsigned NCH            = 4,
    parameter int unsigned STARTUP_CYCLES = 3000,
    parameter int unsigned PERIOD_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CBITS          = 12,
    localparam int unsigned CW            = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_enable,
    input  logic              spi_not_busy,
    input  logic [31:0]       spi_rx_data,
    output logic              spi_ena,
    output logic [CW-1:0]     spi_sel,
    output logic [14*NCH-1:0] tc_temp_data,
    output logic [12*NCH-1:0] junction_temp_data,
    output logic [4*NCH-1:0]  fault_bits,
    output logic [NCH-1:0]    valid,
    output logic [NCH-1:0]    timeout_err,
    output logic              scan_done
);

    typedef enum logic [2:0] {
        StStartup = 3'd0,
        StReq     = 3'd1,
        StBusy    = 3'd2,
        StCapture = 3'd3,
        StPeriod  = 3'd4
    } state_e;

    localparam logic [CBITS-1:0] StartupLast = CBITS'(STARTUP_CYCLES);
    localparam logic [CBITS-1:0] PeriodLast  = CBITS'(PERIOD_CYCLES);
    localparam logic [CBITS-1:0] TimeoutLast = CBITS'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CBITS-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [NCH-1:0]      mask_q, mask_d;
    logic                spi_ena_q, spi_ena_d;
    logic                scan_done_q, scan_done_d;
    logic [14*NCH-1:0]   tc_q, tc_d;
    logic [12*NCH-1:0]   jt_q, jt_d;
    logic [4*NCH-1:0]    fault_q, fault_d;
    logic [NCH-1:0]      valid_q, valid_d;
    logic [NCH-1:0]      tout_q, tout_d;

    logic                capture, timeout, start_scan;
    logic                nxt_found, low_found;
    logic [CW-1:0]       nxt_ch, low_ch;

    // Next enabled channel above the current one, from the mask latched at scan start.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_q))) begin
                nxt_found = 1'b1;
                nxt_ch    = CW'(i);
            end
        end
    end

    // Lowest enabled channel of the live enable vector, used when a new scan starts.
    always_comb begin
        low_found = 1'b0;
        low_ch    = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (ch_enable[i]) begin
                low_found = 1'b1;
                low_ch    = CW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        mask_d      = mask_q;
        spi_ena_d   = 1'b0;
        scan_done_d = 1'b0;
        tc_d        = tc_q;
        jt_d        = jt_q;
        fault_d     = fault_q;
        valid_d     = valid_q;
        tout_d      = tout_q;
        capture     = 1'b0;
        timeout     = 1'b0;
        start_scan  = 1'b0;

        case (state_q)
            StStartup: begin
                if (cnt_q < StartupLast) begin
                    cnt_d = cnt_q + CBITS'(1);
                end else begin
                    start_scan = 1'b1;
                end
            end
            StReq: begin
                cnt_d = cnt_q + CBITS'(1);
                if (!spi_not_busy) begin
                    state_d = StBusy;
                end else if (cnt_q >= TimeoutLast) begin
                    timeout = 1'b1;
                end else begin
                    spi_ena_d = 1'b1;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CBITS'(1);
                // The handshake edge takes priority over an expiring timeout.
                if (spi_not_busy) begin
                    state_d = StCapture;
                end else if (cnt_q >= TimeoutLast) begin
                    timeout = 1'b1;
                end
            end
            StCapture: begin
                capture = 1'b1;
            end
            StPeriod: begin
                if (cnt_q < PeriodLast) begin
                    cnt_d = cnt_q + CBITS'(1);
                end else begin
                    start_scan = 1'b1;
                end
            end
            default: begin
                state_d = StPeriod;
                cnt_d   = '0;
            end
        endcase

        for (int i = 0; i < int'(NCH); i++) begin
            if (ch_q == CW'(i)) begin
                if (capture) begin
                    tc_d[i*14 +: 14]   = spi_rx_data[31:18];
                    jt_d[i*12 +: 12]   = spi_rx_data[15:4];
                    fault_d[i*4 +: 4]  = {spi_rx_data[16], spi_rx_data[2:0]};
                    valid_d[i]         = 1'b1;
                    tout_d[i]          = 1'b0;
                end
                if (timeout) begin
                    valid_d[i] = 1'b0;
                    tout_d[i]  = 1'b1;
                end
            end
        end

        if (capture || timeout) begin
            cnt_d = '0;
            if (nxt_found) begin
                ch_d    = nxt_ch;
                state_d = StReq;
            end else begin
                state_d     = StPeriod;
                scan_done_d = 1'b1;
            end
        end

        if (start_scan) begin
            cnt_d  = '0;
            mask_d = ch_enable;
            if (low_found) begin
                ch_d    = low_ch;
                state_d = StReq;
            end else begin
                state_d     = StPeriod;
                scan_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StStartup;
            cnt_q       <= '0;
            ch_q        <= '0;
            mask_q      <= '0;
            spi_ena_q   <= 1'b0;
            scan_done_q <= 1'b0;
            tc_q        <= '0;
            jt_q        <= '0;
            fault_q     <= '0;
            valid_q     <= '0;
            tout_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            mask_q      <= mask_d;
            spi_ena_q   <= spi_ena_d;
            scan_done_q <= scan_done_d;
            tc_q        <= tc_d;
            jt_q        <= jt_d;
            fault_q     <= fault_d;
            valid_q     <= valid_d;
            tout_q      <= tout_d;
        end
    end

    assign spi_ena            = spi_ena_q;
    assign spi_sel            = ch_q;
    assign tc_temp_data       = tc_q;
    assign junction_temp_data = jt_q;
    assign fault_bits         = fault_q;
    assign valid              = valid_q;
    assign timeout_err        = tout_q;
    assign scan_done          = scan_done_q;

endmodule

// File: tb/tb_thermocouple_scanner.sv
// Directed bench for thermocouple_scanner: a table of whole-scan vectors against a small SPI
// slave model, plus hand sequences for startup timing, empty-mask period and reset in BUSY.
module tb_thermocouple_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  ch_enable;
    logic        spi_not_busy;
    logic [31:0] spi_rx_data;
    logic        spi_ena;
    logic [1:0]  spi_sel;
    logic [55:0] tc_temp_data;
    logic [47:0] junction_temp_data;
    logic [15:0] fault_bits;
    logic [3:0]  valid;
    logic [3:0]  timeout_err;
    logic        scan_done;

    logic [3:0][31:0] resp_cur;
    logic [3:0]       hang_cur;
    logic [15:0]      seq;
    logic             fresh;
    logic [1:0]       sel;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic             rst_first;
        logic [3:0]       en;
        logic [3:0][31:0] resp;
        logic [3:0]       hang;
        logic [55:0]      exp_tc;
        logic [47:0]      exp_jt;
        logic [15:0]      exp_fault;
        logic [3:0]       exp_valid;
        logic [3:0]       exp_tout;
        logic [15:0]      exp_seq;
    } vec_t;

    vec_t vecs [4];

    thermocouple_scanner #(
        .NCH            (4),
        .STARTUP_CYCLES (10),
        .PERIOD_CYCLES  (20),
        .TIMEOUT_CYCLES (8),
        .CBITS          (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ch_enable          (ch_enable),
        .spi_not_busy       (spi_not_busy),
        .spi_rx_data        (spi_rx_data),
        .spi_ena            (spi_ena),
        .spi_sel            (spi_sel),
        .tc_temp_data       (tc_temp_data),
        .junction_temp_data (junction_temp_data),
        .fault_bits         (fault_bits),
        .valid              (valid),
        .timeout_err        (timeout_err),
        .scan_done          (scan_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_scan(input string name);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            if (scan_done) seen = 1'b1;
        end
        check(name, 64'(seen), 64'(1));
    endtask

    // Expect spi_ena quiet for 11 edges after rst release and high on edge 12.
    task automatic check_startup(input string name);
        logic early;
        early = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (spi_ena || scan_done || (valid != 4'h0)) early = 1'b1;
        end
        check({name, "_quiet"}, 64'(early), 64'(0));
        @(negedge clk);
        check({name, "_spi_ena"}, 64'(spi_ena), 64'(1));
        check({name, "_spi_sel"}, 64'(spi_sel), 64'(0));
    endtask

    // SPI slave: drops not_busy after seeing spi_ena, replies after a few cycles; a hung
    // channel stays busy until the scanner moves on to another channel.
    initial begin
        spi_not_busy = 1'b1;
        spi_rx_data  = '0;
        fresh        = 1'b1;
        seq          = '0;
        sel          = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                spi_not_busy = 1'b1;
                fresh        = 1'b1;
            end else begin
                if (scan_done) fresh = 1'b1;
                if (spi_ena) begin
                    sel          = spi_sel;
                    seq          = fresh ? 16'(sel) : {seq[11:0], 4'(sel)};
                    fresh        = 1'b0;
                    spi_not_busy = 1'b0;
                    for (int t = 0; t < 200; t++) begin
                        @(negedge clk);
                        if (rst) break;
                        if (hang_cur[sel] ? (spi_sel != sel) : (t >= 2)) break;
                    end
                    spi_rx_data  = resp_cur[sel];
                    spi_not_busy = 1'b1;
                end
            end
        end
    end

    initial begin
        logic       found;
        logic       ena_seen;
        int         n;

        vecs[0] = '{rst_first: 1'b1, en: 4'hF, resp: {4{32'hABCD_1234}}, hang: 4'h0,
                    exp_tc: {4{14'h2AF3}}, exp_jt: {4{12'h123}}, exp_fault: {4{4'hC}},
                    exp_valid: 4'hF, exp_tout: 4'h0, exp_seq: 16'h0123};
        vecs[1] = '{rst_first: 1'b1, en: 4'b1010,
                    resp: {32'hFFFD_FFF7, 32'h0, 32'h1234_5678, 32'h0}, hang: 4'h0,
                    exp_tc: {14'h3FFF, 14'h0, 14'h048D, 14'h0},
                    exp_jt: {12'hFFF, 12'h0, 12'h567, 12'h0},
                    exp_fault: {4'hF, 4'h0, 4'h0, 4'h0},
                    exp_valid: 4'b1010, exp_tout: 4'h0, exp_seq: 16'h0013};
        vecs[2] = '{rst_first: 1'b0, en: 4'hF,
                    resp: {32'h0001_0005, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0004_0010},
                    hang: 4'b0100,
                    exp_tc: {14'h0, 14'h0, 14'h048D, 14'h0001},
                    exp_jt: {12'h0, 12'h0, 12'h567, 12'h001},
                    exp_fault: {4'hD, 4'h0, 4'h0, 4'h0},
                    exp_valid: 4'b1011, exp_tout: 4'b0100, exp_seq: 16'h0123};
        vecs[3] = '{rst_first: 1'b0, en: 4'b0100, resp: {4{32'hABCD_1234}}, hang: 4'h0,
                    exp_tc: {14'h0, 14'h2AF3, 14'h048D, 14'h0001},
                    exp_jt: {12'h0, 12'h123, 12'h567, 12'h001},
                    exp_fault: {4'hD, 4'hC, 4'h0, 4'h0},
                    exp_valid: 4'hF, exp_tout: 4'h0, exp_seq: 16'h0002};

        // Reset values and startup latency.
        rst       = 1'b1;
        ch_enable = 4'hF;
        resp_cur  = {4{32'hABCD_1234}};
        hang_cur  = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_spi_ena", 64'(spi_ena), 64'(0));
        check("rst_spi_sel", 64'(spi_sel), 64'(0));
        check("rst_tc", 64'(tc_temp_data), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_timeout", 64'(timeout_err), 64'(0));
        check("rst_scan_done", 64'(scan_done), 64'(0));
        rst = 1'b0;
        check_startup("startup");

        // Whole-scan vectors.
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].rst_first) rst = 1'b1;
            ch_enable = vecs[v].en;
            resp_cur  = vecs[v].resp;
            hang_cur  = vecs[v].hang;
            if (vecs[v].rst_first) begin
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            wait_scan($sformatf("v%0d_scan_done", v));
            check($sformatf("v%0d_tc", v), 64'(tc_temp_data), 64'(vecs[v].exp_tc));
            check($sformatf("v%0d_junction", v), 64'(junction_temp_data), 64'(vecs[v].exp_jt));
            check($sformatf("v%0d_fault", v), 64'(fault_bits), 64'(vecs[v].exp_fault));
            check($sformatf("v%0d_valid", v), 64'(valid), 64'(vecs[v].exp_valid));
            check($sformatf("v%0d_timeout", v), 64'(timeout_err), 64'(vecs[v].exp_tout));
            check($sformatf("v%0d_sel_order", v), 64'(seq), 64'(vecs[v].exp_seq));
        end

        // Empty mask: scan_done every PERIOD_CYCLES+1 cycles, no SPI traffic.
        ch_enable = 4'h0;
        wait_scan("empty_first_pulse");
        ena_seen = 1'b0;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (spi_ena) ena_seen = 1'b1;
            end while (!scan_done && n < 100);
            check($sformatf("empty_gap%0d", r), 64'(n), 64'(21));
        end
        check("empty_no_spi_ena", 64'(ena_seen), 64'(0));

        // Reset while the first transaction of a scan is in BUSY.
        ch_enable = 4'hF;
        resp_cur  = {4{32'hABCD_1234}};
        found     = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (!spi_not_busy && !spi_ena) found = 1'b1;
        end
        check("busy_reached", 64'(found), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("busy_rst_spi_ena", 64'(spi_ena), 64'(0));
        check("busy_rst_tc", 64'(tc_temp_data), 64'(0));
        check("busy_rst_junction", 64'(junction_temp_data), 64'(0));
        check("busy_rst_fault", 64'(fault_bits), 64'(0));
        check("busy_rst_valid", 64'(valid), 64'(0));
        check("busy_rst_timeout", 64'(timeout_err), 64'(0));
        check("busy_rst_scan_done", 64'(scan_done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        check_startup("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
